// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_bridge
//  Description : APB requester. Turns a single-entry valid/ready command into
//                an APB SETUP/ACCESS transfer and returns read data or a
//                timeout status on a one-cycle response strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module apb_master_bridge #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16   // ACCESS cycles with pready low before abort, 1..255
) (
  input  logic              clk_i,
  input  logic              reset_i,
  // command port
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  // response port
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_timeout_o,
  // APB requester side
  output logic              psel_o,
  output logic              penable_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic              pready_i,
  input  logic [DATA_W-1:0] prdata_i
);

  // Last wait-count value before the abort fires; the counter is 8 bits wide
  // so TIMEOUT is limited to 255.
  localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t              state_q,       state_d;
  logic                psel_q,        psel_d;
  logic                penable_q,     penable_d;
  logic [ADDR_W-1:0]   paddr_q,       paddr_d;
  logic                pwrite_q,      pwrite_d;
  logic [DATA_W-1:0]   pwdata_q,      pwdata_d;
  logic                rsp_valid_q,   rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q,   rsp_rdata_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic [7:0]          wait_q,        wait_d;

  // State and registered outputs; reset aborts any transfer without a response.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
      wait_q        <= 8'd0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
      wait_q        <= wait_d;
    end
  end

  // Next-state and next-output decode; everything holds unless a transition
  // says otherwise, and the response strobe defaults low so it is one cycle.
  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;
    wait_d        = wait_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          state_d  = ST_SETUP;
          psel_d   = 1'b1;
          paddr_d  = cmd_addr_i;
          pwrite_d = cmd_write_i;
          pwdata_d = cmd_wdata_i;
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
        wait_d    = 8'd0;
      end

      ST_ACCESS: begin
        if (pready_i) begin
          // pready wins even in the last allowed cycle
          state_d       = ST_IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : prdata_i;
          rsp_timeout_d = 1'b0;
        end else if (wait_q == c_WAIT_LAST) begin
          state_d       = ST_IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  assign cmd_ready_o   = (state_q == ST_IDLE);
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign psel_o        = psel_q;
  assign penable_o     = penable_q;
  assign paddr_o       = paddr_q;
  assign pwrite_o      = pwrite_q;
  assign pwdata_o      = pwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_master_bridge
//  Description : Self-checking bench for apb_master_bridge with a simple APB
//                slave model and a transaction-level expected-response model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_apb_master_bridge;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_timeout;
  logic              psel;
  logic              penable;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;

  int checks   = 0;
  int failures = 0;

  // response registers hold between transfers; track what they should hold
  logic [DATA_W-1:0] last_rd = '0;
  logic              last_to = 1'b0;

  apb_master_bridge #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) u_dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_write_i   (cmd_write),
    .cmd_addr_i    (cmd_addr),
    .cmd_wdata_i   (cmd_wdata),
    .rsp_valid_o   (rsp_valid),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_timeout_o (rsp_timeout),
    .psel_o        (psel),
    .penable_o     (penable),
    .paddr_o       (paddr),
    .pwrite_o      (pwrite),
    .pwdata_o      (pwdata),
    .pready_i      (pready),
    .prdata_i      (prdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Idle cycles: nothing moves, response fields hold.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pready = 1'($urandom_range(0, 1));
      prdata = $urandom;
      check_eq("idle_rsp_valid", rsp_valid, 1'b0);
      check_eq("idle_psel", psel, 1'b0);
      check_eq("idle_cmd_ready", cmd_ready, 1'b1);
      check_eq("idle_rsp_rdata_hold", rsp_rdata, last_rd);
      check_eq("idle_rsp_timeout_hold", rsp_timeout, last_to);
    end
  endtask

  // One transfer. Entered at a negedge with the DUT idle; returns at the
  // negedge of the response cycle. The slave raises pready after 'waits'
  // wait states. Expected behaviour is derived from the transfer rules:
  // completion after waits+1 ACCESS cycles unless that exceeds TIMEOUT.
  task automatic run_txn(input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rd,
                         input int waits, input bit keep_valid);
    bit                exp_to;
    int                exp_acc;
    logic [DATA_W-1:0] exp_rd;
    int                acc;
    int                guard;

    exp_to  = (waits >= TIMEOUT);
    exp_acc = exp_to ? TIMEOUT : waits + 1;
    exp_rd  = (wr || exp_to) ? '0 : rd;

    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    check_eq("accept_cmd_ready", cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    if (!keep_valid) cmd_valid = 1'b0;

    // SETUP cycle
    @(negedge clk);
    check_eq("setup_psel", psel, 1'b1);
    check_eq("setup_penable", penable, 1'b0);
    check_eq("setup_paddr", paddr, addr);
    check_eq("setup_pwrite", pwrite, wr);
    if (wr) check_eq("setup_pwdata", pwdata, wd);
    check_eq("setup_cmd_ready", cmd_ready, 1'b0);
    check_eq("setup_rsp_valid", rsp_valid, 1'b0);
    pready = 1'($urandom_range(0, 1));   // must be ignored in SETUP
    prdata = $urandom;

    @(negedge clk);
    acc   = 0;
    guard = 0;
    while (rsp_valid !== 1'b1 && guard < 400) begin
      if (psel === 1'b1 && penable === 1'b1) begin
        acc++;
        check_eq("access_paddr_stable", paddr, addr);
        check_eq("access_cmd_ready", cmd_ready, 1'b0);
        pready = (acc == waits + 1);
        prdata = pready ? rd : $urandom;
      end else begin
        pready = 1'($urandom_range(0, 1));
        prdata = $urandom;
      end
      @(negedge clk);
      guard++;
    end
    pready = 1'b0;

    if (guard >= 400) begin
      check_eq("rsp_never_arrived", 32'd0, 32'd1);
    end else begin
      check_eq("access_cycles", acc, exp_acc);
      check_eq("rsp_timeout", rsp_timeout, exp_to);
      check_eq("rsp_rdata", rsp_rdata, exp_rd);
      check_eq("rsp_psel_low", psel, 1'b0);
      check_eq("rsp_penable_low", penable, 1'b0);
      check_eq("rsp_cmd_ready", cmd_ready, 1'b1);
      check_eq("rsp_paddr_hold", paddr, addr);
    end
    last_rd = exp_rd;
    last_to = exp_to;
  endtask

  // Hard stop if something wedges the main sequence.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic              wr;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rd;
    int                waits;
    int                r;
    bit                keep;
    bit                prev_keep;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    pready    = 1'b0;
    prdata    = '0;

    repeat (2) @(negedge clk);
    check_eq("rst_psel", psel, 1'b0);
    check_eq("rst_penable", penable, 1'b0);
    check_eq("rst_pwrite", pwrite, 1'b0);
    check_eq("rst_paddr", paddr, '0);
    check_eq("rst_pwdata", pwdata, '0);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_rsp_timeout", rsp_timeout, 1'b0);
    check_eq("rst_rsp_rdata", rsp_rdata, '0);
    check_eq("rst_cmd_ready", cmd_ready, 1'b1);
    reset = 1'b0;
    idle_cycles(2);

    // zero-wait write
    run_txn(1'b1, 10'h12A, 32'hDEADBEEF, 32'h0, 0, 1'b0);
    idle_cycles(1);
    // read with 3 wait states
    run_txn(1'b0, 10'h3FF, 32'h0, 32'hA5A55A5A, 3, 1'b0);
    idle_cycles(1);
    // pready stuck low -> timeout
    run_txn(1'b0, 10'h055, 32'h0, 32'h12345678, 1000, 1'b0);
    idle_cycles(1);
    // pready exactly in the last allowed ACCESS cycle -> normal completion
    run_txn(1'b0, 10'h0AA, 32'h0, 32'hCAFEF00D, TIMEOUT - 1, 1'b0);
    idle_cycles(1);
    // one wait state too many -> timeout
    run_txn(1'b1, 10'h101, 32'h01020304, 32'h0, TIMEOUT, 1'b0);
    idle_cycles(1);
    // four back-to-back commands with cmd_valid held high
    run_txn(1'b1, 10'h001, 32'h11111111, 32'h0, 0, 1'b1);
    run_txn(1'b0, 10'h002, 32'h0, 32'h22222222, 1, 1'b1);
    run_txn(1'b1, 10'h003, 32'h33333333, 32'h0, 2, 1'b1);
    run_txn(1'b0, 10'h004, 32'h0, 32'h44444444, 0, 1'b0);
    idle_cycles(2);

    // reset in the middle of ACCESS: outputs drop at once, no response
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 10'h2C3;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);           // SETUP
    @(negedge clk);           // ACCESS
    pready = 1'b0;
    check_eq("pre_rst_access", penable, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_psel", psel, 1'b0);
    check_eq("async_rst_penable", penable, 1'b0);
    check_eq("async_rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("async_rst_cmd_ready", cmd_ready, 1'b1);
    check_eq("async_rst_rsp_rdata", rsp_rdata, '0);
    @(negedge clk);
    reset   = 1'b0;
    last_rd = '0;
    last_to = 1'b0;
    idle_cycles(3);
    run_txn(1'b0, 10'h2C3, 32'h0, 32'h600DCAFE, 1, 1'b0);
    idle_cycles(1);

    // randomized traffic
    prev_keep = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!prev_keep && $urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
      wr = 1'($urandom_range(0, 1));
      a  = ADDR_W'($urandom);
      wd = $urandom;
      rd = $urandom;
      r  = $urandom_range(0, 9);
      if (r < 6)      waits = $urandom_range(0, 4);
      else if (r < 9) waits = $urandom_range(TIMEOUT - 3, TIMEOUT + 1);
      else            waits = 1000;
      keep = (i < 59) && ($urandom_range(0, 1) == 1);
      run_txn(wr, a, wd, rd, waits, keep);
      prev_keep = keep;
    end
    idle_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
